// File: rtl/logu_row.sv
// logu_row: pipelined natural-log row for the softmax / normalisation datapath.
//
// ln(x) is built by reading the float's exponent and mantissa as a signed
// fixed-point log2 value (inverse Schraudolph). An optional quadratic term
// corrects the mantissa, the result is scaled by a quantised ln2, and then
// renormalised to the operand format.
//
// Stages: S1 decode + correction + special class, S2 multiply by ln2,
//         S3 normalise + round. The latency is 3 cycles when nothing stalls.
//
// Ports:
//   clk_i    clock
//   rst_i    synchronous reset, active-high
//   clear_i  synchronous flush of every in-flight operand
//   valid_i  operand valid         ready_o  row can accept the operand
//   op_i     operand x
//   valid_o  result valid          ready_i  consumer accepts the result
//   res_o    ln(x)
//
// FPFORMAT uses the fp_format_e encoding of fpnew_pkg:
// 0=FP32, 1=FP64, 2=FP16, 3=FP8, 4=FP16ALT. The datapath uses 64-bit
// intermediates, so only formats up to FP32 are meaningful.
module logu_row #(
    parameter int  FPFORMAT          = 4,
    parameter bit  ENABLE_CORRECTION = 1'b1,
    parameter real SIGMA_REAL        = 0.34375,
    parameter int  SIGMA_FRACTION    = 6,
    parameter int  LN2_FRACTION      = 12,
    parameter bit  ENABLE_ROUNDING   = 1'b1,
    localparam int EXPONENT_BITS = (FPFORMAT == 0) ? 8  : (FPFORMAT == 1) ? 11 :
                                   (FPFORMAT == 2) ? 5  : (FPFORMAT == 3) ? 5  : 8,
    localparam int MANTISSA_BITS = (FPFORMAT == 0) ? 23 : (FPFORMAT == 1) ? 52 :
                                   (FPFORMAT == 2) ? 10 : (FPFORMAT == 3) ? 2  : 7,
    localparam int WIDTH         = 1 + EXPONENT_BITS + MANTISSA_BITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] op_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] res_o
);

    localparam int E      = EXPONENT_BITS;
    localparam int M      = MANTISSA_BITS;
    localparam int BIAS   = (1 << (E - 1)) - 1;
    localparam int FW     = E + M + 1;           // signed log2 value, M fractional bits
    localparam int PW     = FW + LN2_FRACTION;   // signed product width
    localparam int PFRAC  = M + LN2_FRACTION;    // product fractional bits
    localparam int STAGES = 3;
    localparam int CW     = 2 * M + SIGMA_FRACTION + 2;
    localparam int CSH    = M + SIGMA_FRACTION;  // brings the correction back to M fractional bits

    localparam longint LN2Q   = longint'(0.6931471805599453 * real'(1 << LN2_FRACTION));
    localparam int     SIGMAQ = int'(SIGMA_REAL * real'(1 << SIGMA_FRACTION));

    localparam logic [1:0] C_NUM  = 2'd0;
    localparam logic [1:0] C_NINF = 2'd1;
    localparam logic [1:0] C_PINF = 2'd2;
    localparam logic [1:0] C_NAN  = 2'd3;

    localparam logic [WIDTH-1:0] R_PINF = {1'b0, {E{1'b1}}, {M{1'b0}}};
    localparam logic [WIDTH-1:0] R_NINF = {1'b1, {E{1'b1}}, {M{1'b0}}};
    localparam logic [WIDTH-1:0] R_QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M - 1){1'b0}}};

    typedef struct packed {
        logic [1:0]    cls;
        logic [FW-1:0] f;
    } s1_t;

    typedef struct packed {
        logic [1:0]    cls;
        logic [PW-1:0] p;
    } s2_t;

    logic [STAGES:1] vld_pipe;
    logic            ld1, ld2, ld3;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    logic [WIDTH-1:0] res_d, res_q;

    // Handshake: a stage loads when it is empty or its successor loads.
    assign ld3     = !vld_pipe[3] || ready_i;
    assign ld2     = !vld_pipe[2] || ld3;
    assign ld1     = !vld_pipe[1] || ld2;
    assign ready_o = ld1;
    assign valid_o = vld_pipe[STAGES];
    assign res_o   = res_q;

    // S1: decode, mantissa correction, special-case class
    logic          sgn;
    logic [E-1:0]  ex;
    logic [M-1:0]  mn;
    logic [M:0]    cm;
    logic [CW-1:0] cprod;
    int            corr;
    int            f_int;

    always_comb begin
        sgn   = op_i[WIDTH-1];
        ex    = op_i[WIDTH-2 -: E];
        mn    = op_i[M-1:0];
        cm    = {1'b1, {M{1'b0}}} - {1'b0, mn};   // 1 - m at M fractional bits
        cprod = '0;
        corr  = 0;
        if (ENABLE_CORRECTION) begin
            // sigma*m*(1-m) carries 2M+SIGMA_FRACTION fractional bits; round back to M
            cprod = CW'(mn) * CW'(cm) * CW'(SIGMAQ);
            cprod = cprod + (CW'(1) << (CSH - 1));
            corr  = int'(cprod >> CSH);
        end
        f_int  = (int'(ex) - BIAS) * (1 << M) + int'(mn) + corr;
        s1_d.f = f_int[FW-1:0];

        // NaN is checked first so that -inf and -NaN both map to the canonical NaN
        s1_d.cls = C_NUM;
        if (&ex)
            s1_d.cls = (|mn || sgn) ? C_NAN : C_PINF;
        else if (ex == '0)
            s1_d.cls = C_NINF;
        else if (sgn)
            s1_d.cls = C_NAN;
    end

    // S2: scale by ln2
    longint p_l;

    always_comb begin
        p_l      = longint'($signed(s1_q.f)) * LN2Q;
        s2_d.p   = p_l[PW-1:0];
        s2_d.cls = s1_q.cls;
    end

    // S3: sign/magnitude, normalise, round, select specials
    logic [PW-1:0]  mag;
    logic [PW-1:0]  norm;
    logic [M-1:0]   frac;
    logic           grd, stk, rnd;
    logic [E+M-1:0] mres;
    int             lead;
    int             ebias;

    always_comb begin
        mag = s2_q.p[PW-1] ? PW'(~s2_q.p + PW'(1)) : s2_q.p;
        lead = 0;
        for (int i = 0; i < PW; i++)
            if (mag[i]) lead = i;
        norm  = mag << (PW - 1 - lead);
        frac  = norm[PW-2 -: M];
        grd   = norm[PW-2-M];
        stk   = |norm[PW-3-M:0];
        rnd   = ENABLE_ROUNDING && grd && (stk || frac[0]);
        ebias = lead - PFRAC + BIAS;
        // a carry out of the mantissa lands in the exponent field
        mres  = {ebias[E-1:0], frac} + (E + M)'(rnd);

        res_d = {s2_q.p[PW-1], mres};
        if (mag == '0)
            res_d = '0;
        unique case (s2_q.cls)
            C_NINF:  res_d = R_NINF;
            C_PINF:  res_d = R_PINF;
            C_NAN:   res_d = R_QNAN;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            vld_pipe <= '0;
        end else begin
            if (ld1) vld_pipe[1] <= valid_i;
            if (ld2) vld_pipe[2] <= vld_pipe[1];
            if (ld3) vld_pipe[3] <= vld_pipe[2];
        end
    end

    // Data moves only with a valid operand so that res_o stays put across bubbles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q  <= '0;
            s2_q  <= '0;
            res_q <= '0;
        end else if (!clear_i) begin
            if (ld1 && valid_i)     s1_q  <= s1_d;
            if (ld2 && vld_pipe[1]) s2_q  <= s2_d;
            if (ld3 && vld_pipe[2]) res_q <= res_d;
        end
    end

endmodule
